// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// default geometry, write-FSM encoding and the hex decode table.
package seg_scan_ctrl_pkg;

  localparam int NDIG_DEF  = 8;
  localparam int DIV_DEF   = 50000;
  localparam int BLANK_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } wr_state_e;

  // Active-high {a,b,c,d,e,f,g,dp}, indexed by nibble value.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'hDE, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seg_hex_dec.sv
// Hex nibble to active-low segment decoder; disabled means all segments off.
module seg_hex_dec
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] val,
  input  logic       en,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    if (en) seg = ~HEX_SEG[val];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a one-deep frame buffer
// that is committed to the display only at frame boundaries.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int DIV   = DIV_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]   wr_ena,
  input  logic              lz_en,
  output logic [7:0]        seg_out,
  output logic [NDIG-1:0]   an_out
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(NDIG);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             tick, frame_end;

  wr_state_e state, state_nxt;
  logic      capture, load;

  logic [NDIG-1:0][3:0] pend_data, disp_data;
  logic [NDIG-1:0]      pend_ena, disp_ena;
  logic                 pend_lz, disp_lz;

  logic [NDIG:0]   zero_above;
  logic [NDIG-1:0] supp;
  logic            show;

  // Slot timing
  assign tick      = (cnt == CNT_W'(DIV - 1));
  assign frame_end = tick && (idx == IDX_W'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // Write FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (wr_valid)  state_nxt = ST_PEND;
      ST_PEND: if (frame_end) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state == ST_IDLE);
    capture  = (state == ST_IDLE) && wr_valid;
    load     = (state == ST_PEND) && frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_ena  <= '0;
      pend_lz   <= 1'b0;
      disp_data <= '0;
      disp_ena  <= '0;
      disp_lz   <= 1'b0;
    end else begin
      if (capture) begin
        pend_data <= wr_data;
        pend_ena  <= wr_ena;
        pend_lz   <= lz_en;
      end
      if (load) begin
        disp_data <= pend_data;
        disp_ena  <= pend_ena;
        disp_lz   <= pend_lz;
      end
    end
  end

  // Leading-zero suppression: a digit is blank when it and everything above is zero.
  assign zero_above[NDIG] = 1'b1;
  for (genvar i = NDIG - 1; i >= 0; i--) begin : g_lz
    assign zero_above[i] = (disp_data[i] == 4'h0) && zero_above[i+1];
    if (i == 0) begin : g_d0
      assign supp[i] = 1'b0;
    end else begin : g_dn
      assign supp[i] = disp_lz && zero_above[i];
    end
  end

  assign show   = disp_ena[idx] && !supp[idx] && (cnt >= CNT_W'(BLANK));
  assign an_out = show ? ~(NDIG'(1) << idx) : '1;

  seg_hex_dec u_dec (
    .val (disp_data[idx]),
    .en  (show),
    .seg (seg_out)
  );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at NDIG=4, DIV=4, BLANK=1 (16-cycle frames).
module tb_seg_scan_ctrl;

  localparam int NDIG = 4, DIV = 4, BLANK = 1;

  logic        clk, rst_n, wr_valid, lz_en;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_ena, an_out;
  logic [7:0]  seg_out;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_ena   (wr_ena),
    .lz_en    (lz_en),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      ena;
    logic            lz;
    logic [3:0][3:0] an;
    logic [3:0][7:0] seg;
  } vec_t;

  vec_t vt [12];
  vec_t vb;
  int   n_chk, n_fail, cyc;

  task automatic chk_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Frame expectation for the current slot: cycle 0 of each slot is ghost-blanked.
  task automatic chk_frame(input vec_t v, input string tag);
    int s, i, c;
    s = cyc % 16; i = s / 4; c = s % 4;
    if (c < BLANK) begin
      chk_eq({tag, "_an"},  {4'h0, an_out}, 8'h0F);
      chk_eq({tag, "_seg"}, seg_out,        8'hFF);
    end else begin
      chk_eq({tag, "_an"},  {4'h0, an_out}, {4'h0, v.an[i]});
      chk_eq({tag, "_seg"}, seg_out,        v.seg[i]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer(input vec_t v);
    wr_valid = 1'b1;
    wr_data  = v.data;
    wr_ena   = v.ena;
    lz_en    = v.lz;
  endtask

  initial begin
    vt[0]  = '{16'h3210, 4'hF, 1'b0, {4'h7,4'hB,4'hD,4'hE}, {8'h0D,8'h25,8'h9F,8'h03}};
    vt[1]  = '{16'h00A0, 4'hF, 1'b1, {4'hF,4'hF,4'hD,4'hE}, {8'hFF,8'hFF,8'h11,8'h03}};
    vt[2]  = '{16'h0000, 4'hF, 1'b1, {4'hF,4'hF,4'hF,4'hE}, {8'hFF,8'hFF,8'hFF,8'h03}};
    vt[3]  = '{16'hC5F8, 4'h6, 1'b0, {4'hF,4'hB,4'hD,4'hF}, {8'hFF,8'h49,8'h71,8'hFF}};
    vt[4]  = '{16'h0907, 4'hF, 1'b1, {4'hF,4'hB,4'hD,4'hE}, {8'hFF,8'h09,8'h03,8'h1F}};
    vt[5]  = '{16'h4DCE, 4'hF, 1'b0, {4'h7,4'hB,4'hD,4'hE}, {8'h99,8'h85,8'h63,8'h21}};
    vt[6]  = '{16'h1B6A, 4'hF, 1'b1, {4'h7,4'hB,4'hD,4'hE}, {8'h9F,8'hC1,8'h41,8'h11}};
    vt[7]  = '{16'h0080, 4'hF, 1'b1, {4'hF,4'hF,4'hD,4'hE}, {8'hFF,8'hFF,8'h01,8'h03}};
    vt[8]  = '{16'h0123, 4'hF, 1'b0, {4'h7,4'hB,4'hD,4'hE}, {8'h03,8'h9F,8'h25,8'h0D}};
    vt[9]  = '{16'h3333, 4'hF, 1'b1, {4'h7,4'hB,4'hD,4'hE}, {8'h0D,8'h0D,8'h0D,8'h0D}};
    vt[10] = '{16'h5555, 4'hF, 1'b0, {4'h7,4'hB,4'hD,4'hE}, {8'h49,8'h49,8'h49,8'h49}};
    vt[11] = '{16'hFFFF, 4'hF, 1'b0, {4'h7,4'hB,4'hD,4'hE}, {8'h71,8'h71,8'h71,8'h71}};
    vb     = '{16'h0000, 4'h0, 1'b0, {4'hF,4'hF,4'hF,4'hF}, {8'hFF,8'hFF,8'hFF,8'hFF}};

    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_ena = '0; lz_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_an",    {4'h0, an_out}, 8'h0F);
    chk_eq("rst_seg",   seg_out,        8'hFF);
    chk_eq("rst_ready", {7'h0, wr_ready}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    chk_frame(vb, "idle");

    // No write: dark display for 100 cycles
    for (int k = 0; k < 100; k++) begin
      step();
      chk_frame(vb, "idle");
      chk_eq("idle_ready", {7'h0, wr_ready}, 8'h01);
    end
    while (cyc % 16 != 0) begin
      step();
      chk_frame(vb, "idle");
    end

    // Table: each frame offered at slot 0, shown from the following frame end
    for (int v = 0; v < 8; v++) begin
      chk_eq("tbl_ready_idle", {7'h0, wr_ready}, 8'h01);
      offer(vt[v]);
      step();
      wr_valid = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if (k > 1) step();
        chk_eq("tbl_ready_pend", {7'h0, wr_ready}, 8'h00);
        chk_frame((v == 0) ? vb : vt[v-1], "tbl_prev");
      end
      step();
      chk_frame(vt[v], "tbl_new");
    end

    // Second offer while pending must not overwrite the captured frame
    offer(vt[8]);
    step();
    offer(vt[9]);
    for (int k = 1; k < 16; k++) begin
      if (k > 1) step();
      chk_eq("pend_ready", {7'h0, wr_ready}, 8'h00);
      chk_frame(vt[7], "pend_prev");
    end
    step();
    chk_frame(vt[8], "pend_x");
    chk_eq("pend_ready_after", {7'h0, wr_ready}, 8'h01);
    step();
    wr_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      if (k > 1) step();
      chk_frame(vt[8], "pend_x");
    end
    step();
    chk_frame(vt[9], "pend_y");

    // Capture coincident with frame end: old frame stays one full extra frame
    for (int k = 1; k < 16; k++) begin
      step();
      chk_frame(vt[9], "coin_y");
    end
    chk_eq("coin_ready", {7'h0, wr_ready}, 8'h01);
    offer(vt[10]);
    step();
    wr_valid = 1'b0;
    chk_eq("coin_ready_pend", {7'h0, wr_ready}, 8'h00);
    chk_frame(vt[9], "coin_hold");
    for (int k = 1; k < 16; k++) begin
      step();
      chk_frame(vt[9], "coin_hold");
    end
    step();
    chk_frame(vt[10], "coin_z");
    chk_eq("coin_ready_z", {7'h0, wr_ready}, 8'h01);

    // Reset mid-slot on digit 2 with a frame pending
    offer(vt[11]);
    step();
    wr_valid = 1'b0;
    while (cyc % 16 != 10) begin
      chk_frame(vt[10], "mid_z");
      step();
    end
    chk_frame(vt[10], "mid_z");
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_an",    {4'h0, an_out}, 8'h0F);
    chk_eq("mid_rst_seg",   seg_out,        8'hFF);
    chk_eq("mid_rst_ready", {7'h0, wr_ready}, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    chk_frame(vb, "post_rst");
    for (int k = 0; k < 48; k++) begin
      step();
      chk_frame(vb, "post_rst");
      chk_eq("post_rst_ready", {7'h0, wr_ready}, 8'h01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 8: number of multiplexed digits (power of two, 2..8).
REQ-002 Parameter DIV, default 50000: clk cycles per digit slot (>= BLANK+2).
REQ-003 Parameter BLANK, default 2: ghost-blank cycles at start of each slot (0..DIV-2).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wr_valid  in  1  new frame offered.
REQ-007 wr_ready  out  1  controller can accept a frame.
REQ-008 wr_data  in  4*NDIG  hex nibbles; nibble i drives digit i.
REQ-009 wr_ena  in  NDIG  per-digit enable; 0 blanks that digit.
REQ-010 lz_en  in  1  leading-zero suppression enable; sampled with the frame.
REQ-011 seg_out  out  8  active-low segments {a..g,dp}, shared across digits.
REQ-012 an_out  out  NDIG  active-low digit select; at most one bit low.

Function
REQ-013 Slot counter cnt counts 0..DIV-1 and wraps; tick is cnt==DIV-1.
REQ-014 On tick, idx advances to (idx+1) mod NDIG; frame end is tick with idx==NDIG-1.
REQ-015 Write FSM states: IDLE (wr_ready=1) and PEND (wr_ready=0).
REQ-016 IDLE: wr_valid=1 captures wr_data/wr_ena/lz_en into the pending register, then go to PEND.
REQ-017 PEND: on frame end, copy pending into display registers and go to IDLE; wr_ready is 1 from the next cycle.
REQ-018 Display registers change only at frame end, so a frame is never torn mid-scan.
REQ-019 A wr_valid presented while wr_ready=0 is ignored; the producer holds it until accepted.
REQ-020 Capture and frame end in the same cycle, while in IDLE: capture only; the new frame loads at the next frame end.
REQ-021 Leading-zero suppression, when the displayed lz_en=1: digit i is blanked if every nibble j>=i is 0; digit 0 is never blanked by suppression.
REQ-022 Digit show = disp_ena[idx] and not suppressed[idx] and (cnt >= BLANK).
REQ-023 an_out = ~(1<<idx) when show=1; all ones otherwise.
REQ-024 seg_out = active-low hex decode of disp_data[idx] when show=1; 8'hFF otherwise.
REQ-025 Decode table (active-high a..g,dp): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE B=3E C=9C D=7A E=DE F=8E.
REQ-026 an_out and seg_out are derived from registered state only; both change in the same cycle, with no combinational path from wr_* to either output.

Reset
REQ-027 rst_n low clears immediately: cnt=0, idx=0, pending and display data=0, enables=0, lz=0, FSM=IDLE.
REQ-028 Outputs during and after reset: wr_ready=1, an_out all ones, seg_out=8'hFF.
REQ-029 Reset mid-frame discards any pending frame; scanning restarts at digit 0, cnt=0.

Structure
REQ-030 A shared package holds the decode table constants, the FSM state encoding and the default NDIG/DIV/BLANK values.
REQ-031 A single sub-module seg_hex_dec (4-bit value plus enable in, 8-bit active-low segments out) is instantiated once and shared by all digits.

Verification
REQ-032 Parameters for all scenarios: NDIG=4, DIV=4, BLANK=1.
REQ-033 Reset release, no write -> an_out=4'hF and seg_out=8'hFF for 100 cycles; wr_ready=1.
REQ-034 Write data=16'h3210, ena=4'hF, lz=0 -> after the next frame end, each slot shows: cycle 0 an=F, seg=FF; cycles 1-3 an=~(1<<i), seg=~table[i]; digit order 0,1,2,3.
REQ-035 Write 16'h00A0 with lz=1 -> digits 3,2 blanked, digit 1 shows seg=~EE=11, digit 0 shows ~FC=03.
REQ-036 Second wr_valid during PEND -> wr_ready=0 and frame not captured; accepted after the frame end.
REQ-037 Frame end coincident with a write in IDLE -> old frame persists one more full frame (16 cycles).
REQ-038 rst_n pulse mid-slot on digit 2 with a pending frame -> outputs go to F/FF immediately; the pending frame is never displayed.
